// File: rtl/eqy_miter_monitor_pkg.sv
// Shared types and helpers for the gold-vs-gate equivalence monitor.
// Holds the FSM state encoding and the saturating counter increment.
package eqy_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    HALT   = 2'd3
  } state_t;

  // Callers zero-extend their counter to 32 bits and pass their own all-ones limit.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max_val);
    return (cnt >= max_val) ? cnt : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/eqy_miter_monitor_if.sv
// Bundle of the monitor's control, sample and result signals.
// master drives controls and samples; slave is the monitor itself.
interface eqy_miter_monitor_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32,
  parameter int CNT_W  = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                      enable;
  logic                      clear;
  logic [NUM_CH-1:0]         in_valid;
  logic [NUM_CH*WIDTH-1:0]   in_gold;
  logic [NUM_CH*WIDTH-1:0]   in_gate;
  logic [NUM_CH*WIDTH-1:0]   in_care;
  logic [NUM_CH-1:0]         fail_ch;
  logic                      fail_any;
  logic [CH_W-1:0]           first_ch;
  logic [WIDTH-1:0]          first_diff;
  logic [CNT_W-1:0]          first_cyc;
  logic [NUM_CH*CNT_W-1:0]   err_cnt;
  logic                      checking;

  modport master (
    output enable, clear, in_valid, in_gold, in_gate, in_care,
    input  fail_ch, fail_any, first_ch, first_diff, first_cyc, err_cnt, checking
  );

  modport slave (
    input  enable, clear, in_valid, in_gold, in_gate, in_care,
    output fail_ch, fail_any, first_ch, first_diff, first_cyc, err_cnt, checking
  );

endinterface

// File: rtl/eqy_miter_monitor_chan.sv
// One compared channel: masked gold/gate XOR, sticky fail flag and
// saturating mismatch counter.
module eqy_mon_chan
  import eqy_mon_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmp_en_i,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] gold_i,
  input  logic [WIDTH-1:0] gate_i,
  input  logic [WIDTH-1:0] care_i,
  output logic             mismatch_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             fail_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic             fail_q, fail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign diff_o     = (gold_i ^ gate_i) & care_i;
  assign mismatch_o = cmp_en_i & valid_i & (|diff_o);

  // clear wins over a same-cycle mismatch, which is then dropped
  always_comb begin
    fail_d = fail_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      fail_d = 1'b0;
      cnt_d  = '0;
    end else if (mismatch_o) begin
      fail_d = 1'b1;
      cnt_d  = CNT_W'(sat_inc(32'(cnt_q), CNT_MAX));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      fail_q <= fail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign fail_o = fail_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/eqy_miter_monitor.sv
// Clocked multi-channel gold-vs-gate equivalence monitor: settle window,
// per-channel sticky flags/counters, and first-failure capture.
//
//   state  | meaning
//   IDLE   | disarmed; results held
//   SETTLE | armed, waiting SETTLE_CYCLES before comparisons count
//   CHECK  | comparing every cycle, stamping checked cycles
//   HALT   | stopped after a mismatch (HALT_ON_FAIL); clear re-arms
module eqy_miter_monitor
  import eqy_mon_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16,
  parameter int HALT_ON_FAIL  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  eqy_miter_monitor_if.slave mon_if
);

  localparam int          CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int          SET_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [31:0] CNT_MAX     = 32'((64'd1 << CNT_W) - 64'd1);

  state_t             state_q, state_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic               fail_any_q, fail_any_d;
  logic               cap_q, cap_d;
  logic [CH_W-1:0]    first_ch_q, first_ch_d;
  logic [WIDTH-1:0]   first_diff_q, first_diff_d;
  logic [CNT_W-1:0]   first_cyc_q, first_cyc_d;

  logic               cmp_en;
  logic [NUM_CH-1:0]  mis_w;
  logic [NUM_CH-1:0]  fail_w;
  logic [WIDTH-1:0]   diff_w [NUM_CH];
  logic [NUM_CH*CNT_W-1:0] err_w;
  logic               hit;
  logic [CH_W-1:0]    sel_ch;
  logic [WIDTH-1:0]   sel_diff;
  logic [CNT_W-1:0]   stamp;

  assign cmp_en = (state_q == CHECK) & mon_if.enable;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    eqy_mon_chan #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmp_en_i   (cmp_en),
      .clear_i    (mon_if.clear),
      .valid_i    (mon_if.in_valid[c]),
      .gold_i     (mon_if.in_gold[c*WIDTH +: WIDTH]),
      .gate_i     (mon_if.in_gate[c*WIDTH +: WIDTH]),
      .care_i     (mon_if.in_care[c*WIDTH +: WIDTH]),
      .mismatch_o (mis_w[c]),
      .diff_o     (diff_w[c]),
      .fail_o     (fail_w[c]),
      .cnt_o      (err_w[c*CNT_W +: CNT_W])
    );
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    unique case (state_q)
      IDLE: begin
        if (mon_if.enable) begin
          if (SETTLE_CYCLES == 0) begin
            state_d = CHECK;
          end else begin
            state_d  = SETTLE;
            settle_d = SETTLE_LOAD;
          end
        end
      end
      SETTLE: begin
        if (settle_q == '0) state_d  = CHECK;
        else                settle_d = settle_q - 1'b1;
      end
      CHECK: begin
        if ((HALT_ON_FAIL != 0) && (|mis_w) && !mon_if.clear) state_d = HALT;
      end
      HALT: begin
        if (mon_if.clear) state_d = CHECK;
      end
    endcase
    if (!mon_if.enable) begin
      state_d  = IDLE;
      settle_d = '0;
    end
  end

  // Scan downwards so the lowest failing index is the one left selected
  always_comb begin
    hit      = 1'b0;
    sel_ch   = '0;
    sel_diff = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (mis_w[c]) begin
        hit      = 1'b1;
        sel_ch   = CH_W'(c);
        sel_diff = diff_w[c];
      end
    end
  end

  assign stamp = CNT_W'(sat_inc(32'(cyc_q), CNT_MAX));

  always_comb begin
    cyc_d        = cyc_q;
    fail_any_d   = |fail_w;
    cap_d        = cap_q;
    first_ch_d   = first_ch_q;
    first_diff_d = first_diff_q;
    first_cyc_d  = first_cyc_q;
    if (mon_if.clear) begin
      cyc_d        = '0;
      fail_any_d   = 1'b0;
      cap_d        = 1'b0;
      first_ch_d   = '0;
      first_diff_d = '0;
      first_cyc_d  = '0;
    end else if (cmp_en) begin
      cyc_d = stamp;
      if (hit && !fail_any_q && !cap_q) begin
        cap_d        = 1'b1;
        first_ch_d   = sel_ch;
        first_diff_d = sel_diff;
        first_cyc_d  = stamp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      settle_q     <= '0;
      cyc_q        <= '0;
      fail_any_q   <= 1'b0;
      cap_q        <= 1'b0;
      first_ch_q   <= '0;
      first_diff_q <= '0;
      first_cyc_q  <= '0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      cyc_q        <= cyc_d;
      fail_any_q   <= fail_any_d;
      cap_q        <= cap_d;
      first_ch_q   <= first_ch_d;
      first_diff_q <= first_diff_d;
      first_cyc_q  <= first_cyc_d;
    end
  end

  assign mon_if.fail_ch    = fail_w;
  assign mon_if.fail_any   = fail_any_q;
  assign mon_if.first_ch   = first_ch_q;
  assign mon_if.first_diff = first_diff_q;
  assign mon_if.first_cyc  = first_cyc_q;
  assign mon_if.err_cnt    = err_w;
  assign mon_if.checking   = (state_q == CHECK);

endmodule

// File: tb/tb_eqy_miter_monitor.sv
// Bench for eqy_miter_monitor: a rule-level model tracks the default instance
// every cycle; two CNT_W=4 instances cover saturation and halt behaviour.
`timescale 1ns/1ps
module tb_eqy_miter_monitor;

  localparam int NCH = 4;
  localparam int W   = 32;
  localparam int S_A = 2;
  localparam int MAXA = 65535;

  logic clk = 1'b0;
  logic rst_n;
  logic enable, clear;
  logic [NCH-1:0]   valid;
  logic [NCH*W-1:0] gold, gate, care;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  eqy_miter_monitor_if #(.NUM_CH(NCH), .WIDTH(W), .CNT_W(16)) ifa ();
  eqy_miter_monitor_if #(.NUM_CH(NCH), .WIDTH(W), .CNT_W(4))  ifb ();
  eqy_miter_monitor_if #(.NUM_CH(NCH), .WIDTH(W), .CNT_W(4))  ifc ();

  assign ifa.enable = enable;  assign ifb.enable = enable;  assign ifc.enable = enable;
  assign ifa.clear  = clear;   assign ifb.clear  = clear;   assign ifc.clear  = clear;
  assign ifa.in_valid = valid; assign ifb.in_valid = valid; assign ifc.in_valid = valid;
  assign ifa.in_gold = gold;   assign ifb.in_gold = gold;   assign ifc.in_gold = gold;
  assign ifa.in_gate = gate;   assign ifb.in_gate = gate;   assign ifc.in_gate = gate;
  assign ifa.in_care = care;   assign ifb.in_care = care;   assign ifc.in_care = care;

  eqy_miter_monitor #(.NUM_CH(NCH), .WIDTH(W), .SETTLE_CYCLES(S_A), .CNT_W(16), .HALT_ON_FAIL(0))
    dut_a (.clk(clk), .rst_n(rst_n), .mon_if(ifa));
  eqy_miter_monitor #(.NUM_CH(NCH), .WIDTH(W), .SETTLE_CYCLES(2), .CNT_W(4), .HALT_ON_FAIL(0))
    dut_b (.clk(clk), .rst_n(rst_n), .mon_if(ifb));
  eqy_miter_monitor #(.NUM_CH(NCH), .WIDTH(W), .SETTLE_CYCLES(2), .CNT_W(4), .HALT_ON_FAIL(1))
    dut_c (.clk(clk), .rst_n(rst_n), .mon_if(ifc));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of instance A ----------------
  bit          m_fail [NCH];
  int unsigned m_cnt  [NCH];
  bit          m_fa, m_cap;
  int          m_fch;
  logic [31:0] m_fdiff;
  int unsigned m_stamp, m_fcyc;
  int          m_run;   // consecutive clock edges with enable high

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin m_fail[c] = 0; m_cnt[c] = 0; end
    m_fa = 0; m_cap = 0; m_fch = 0; m_fdiff = '0; m_stamp = 0; m_fcyc = 0; m_run = 0;
  endtask

  task automatic model_step();
    bit cmp, fa_new;
    int low;
    logic [31:0] d, ld;
    cmp    = enable && (m_run > S_A);
    m_run  = enable ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
    fa_new = !clear && (m_fail[0] || m_fail[1] || m_fail[2] || m_fail[3]);
    ld     = '0;
    if (clear) begin
      for (int c = 0; c < NCH; c++) begin m_fail[c] = 0; m_cnt[c] = 0; end
      m_cap = 0; m_fch = 0; m_fdiff = '0; m_fcyc = 0; m_stamp = 0;
    end else if (cmp) begin
      m_stamp = (m_stamp < MAXA) ? m_stamp + 1 : MAXA;
      low = -1;
      for (int c = 0; c < NCH; c++) begin
        d = (gold[c*W +: W] ^ gate[c*W +: W]) & care[c*W +: W];
        if (valid[c] && d != 0) begin
          m_fail[c] = 1;
          if (m_cnt[c] < MAXA) m_cnt[c]++;
          if (low < 0) begin low = c; ld = d; end
        end
      end
      if (low >= 0 && !m_fa && !m_cap) begin
        m_cap = 1; m_fch = low; m_fdiff = ld; m_fcyc = m_stamp;
      end
    end
    m_fa = fa_new;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  initial begin
    logic [63:0] e_cnt;
    forever begin
      @(negedge clk);
      e_cnt = {16'(m_cnt[3]), 16'(m_cnt[2]), 16'(m_cnt[1]), 16'(m_cnt[0])};
      chk("a_fail_ch",    64'(ifa.fail_ch),    64'({m_fail[3], m_fail[2], m_fail[1], m_fail[0]}));
      chk("a_fail_any",   64'(ifa.fail_any),   64'(m_fa));
      chk("a_first_ch",   64'(ifa.first_ch),   64'(m_fch));
      chk("a_first_diff", 64'(ifa.first_diff), 64'(m_fdiff));
      chk("a_first_cyc",  64'(ifa.first_cyc),  64'(m_fcyc));
      chk("a_err_cnt",    ifa.err_cnt,         e_cnt);
      chk("a_checking",   64'(ifa.checking),   64'(m_run > S_A));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_equal();
    for (int c = 0; c < NCH; c++) begin
      gold[c*W +: W] = $urandom;
      care[c*W +: W] = $urandom;
    end
    gate  = gold;
    valid = '1;
  endtask

  task automatic set_mis(input int c, input logic [31:0] x);
    gate[c*W +: W] = gold[c*W +: W] ^ x;
    care[c*W +: W] = '1;
  endtask

  // Asserts reset between edges and checks the asynchronous clear, then releases.
  task automatic do_reset(input bit keep_en);
    rst_n = 1'b0;
    clear = 1'b0;
    if (!keep_en) enable = 1'b0;
    #1;
    chk("rst_fail_ch",    64'(ifa.fail_ch),    64'h0);
    chk("rst_fail_any",   64'(ifa.fail_any),   64'h0);
    chk("rst_first_diff", 64'(ifa.first_diff), 64'h0);
    chk("rst_first_cyc",  64'(ifa.first_cyc),  64'h0);
    chk("rst_err_cnt",    ifa.err_cnt,         64'h0);
    chk("rst_checking",   64'(ifa.checking),   64'h0);
    chk("rst_c_checking", 64'(ifc.checking),   64'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0;
    set_equal();
    repeat (2) @(posedge clk);
    #1;

    // equal data: checking rises after the third enabled edge, no failures
    do_reset(1'b0);
    enable = 1'b1; set_equal();
    tick(); chk("t1_chk_e1", 64'(ifa.checking), 64'h0);
    set_equal();
    tick(); chk("t1_chk_e2", 64'(ifa.checking), 64'h0);
    set_equal();
    tick(); chk("t1_chk_e3", 64'(ifa.checking), 64'h1);
    repeat (97) begin set_equal(); tick(); end
    chk("t1_fail_any", 64'(ifa.fail_any), 64'h0);
    chk("t1_err_cnt",  ifa.err_cnt,       64'h0);
    chk("t1_checking", 64'(ifa.checking), 64'h1);

    // mismatch while settling is ignored; ch2 fails on the fifth checked cycle
    do_reset(1'b0);
    enable = 1'b1; set_equal(); tick();
    set_equal(); gate = ~gold; care = '1; tick();
    set_equal(); tick();
    repeat (4) begin set_equal(); tick(); end
    chk("t2_no_settle_fail", 64'(ifa.fail_ch), 64'h0);
    set_equal(); set_mis(2, 32'h10); tick();
    chk("t2_fail_ch",    64'(ifa.fail_ch),    64'b0100);
    chk("t2_first_ch",   64'(ifa.first_ch),   64'd2);
    chk("t2_first_diff", 64'(ifa.first_diff), 64'h10);
    chk("t2_first_cyc",  64'(ifa.first_cyc),  64'd5);
    chk("t2_fail_any_n", 64'(ifa.fail_any),   64'h0);
    set_equal(); tick();
    chk("t2_fail_any_n1", 64'(ifa.fail_any), 64'h1);

    // reset with flags set, enable held: SETTLE then CHECK two cycles later
    do_reset(1'b1);
    set_equal();
    tick(); chk("t6_chk_e1", 64'(ifa.checking), 64'h0);
    tick(); chk("t6_chk_e2", 64'(ifa.checking), 64'h0);
    tick(); chk("t6_chk_e3", 64'(ifa.checking), 64'h1);

    // differences only in don't-care bits, or on invalid channels
    repeat (5) begin
      set_equal();
      for (int c = 0; c < NCH; c++) begin
        gate[c*W +: W] = gold[c*W +: W] ^ 32'hFF00;
        care[c*W +: W] = 32'h00FF;
      end
      tick();
    end
    repeat (5) begin set_equal(); gate = ~gold; care = '1; valid = '0; tick(); end
    chk("t3_fail_ch",  64'(ifa.fail_ch),  64'h0);
    chk("t3_err_cnt",  ifa.err_cnt,       64'h0);
    chk("t3_fail_any", 64'(ifa.fail_any), 64'h0);

    // simultaneous ch1/ch3 first failures: lowest index captured
    set_equal(); set_mis(1, 32'h100); set_mis(3, 32'h8000_0000); tick();
    chk("t4_fail_ch",    64'(ifa.fail_ch),           64'b1010);
    chk("t4_first_ch",   64'(ifa.first_ch),          64'd1);
    chk("t4_first_diff", 64'(ifa.first_diff),        64'h100);
    chk("t4_cnt1",       64'(ifa.err_cnt[31:16]),    64'd1);
    chk("t4_cnt3",       64'(ifa.err_cnt[63:48]),    64'd1);
    chk("t4_cnt0",       64'(ifa.err_cnt[15:0]),     64'd0);

    // clear beats a same-cycle mismatch
    set_equal(); set_mis(0, 32'h1); clear = 1'b1; tick();
    clear = 1'b0;
    chk("clr_fail_ch",    64'(ifa.fail_ch),    64'h0);
    chk("clr_err_cnt",    ifa.err_cnt,         64'h0);
    chk("clr_first_diff", 64'(ifa.first_diff), 64'h0);
    chk("clr_checking",   64'(ifa.checking),   64'h1);
    set_equal(); tick();
    chk("clr_fail_any", 64'(ifa.fail_any), 64'h0);

    // CNT_W=4 saturation (B) and halt-on-fail (C)
    do_reset(1'b0);
    enable = 1'b1;
    repeat (3) begin set_equal(); tick(); end
    chk("t5_c_checking", 64'(ifc.checking), 64'h1);
    set_equal(); set_mis(0, 32'h1); tick();
    chk("t5_c_halt",    64'(ifc.checking),      64'h0);
    chk("t5_c_cnt1",    64'(ifc.err_cnt[3:0]),  64'd1);
    chk("t5_c_fail_ch", 64'(ifc.fail_ch),       64'b0001);
    repeat (19) begin set_equal(); set_mis(0, 32'h1); tick(); end
    chk("t5_b_sat",      64'(ifb.err_cnt[3:0]),  64'd15);
    chk("t5_b_first_cyc",64'(ifb.first_cyc),     64'd1);
    chk("t5_c_held",     64'(ifc.err_cnt[3:0]),  64'd1);
    chk("t5_a_cnt20",    64'(ifa.err_cnt[15:0]), 64'd20);
    set_equal(); clear = 1'b1; tick();
    clear = 1'b0;
    chk("t5_c_rearm",    64'(ifc.checking), 64'h1);
    chk("t5_c_err_clr",  64'(ifc.err_cnt),  64'h0);
    chk("t5_c_fail_clr", 64'(ifc.fail_ch),  64'h0);
    chk("t5_b_err_clr",  64'(ifb.err_cnt),  64'h0);
    repeat (20) begin set_equal(); tick(); end
    set_equal(); set_mis(0, 32'h4); tick();
    chk("t5_b_stamp_sat", 64'(ifb.first_cyc), 64'd15);

    // randomized traffic, tracked by the model each cycle
    for (int i = 0; i < 1500; i++) begin
      enable = ($urandom_range(0, 99) < 97);
      clear  = ($urandom_range(0, 99) < 4);
      for (int c = 0; c < NCH; c++) begin
        gold[c*W +: W] = $urandom;
        care[c*W +: W] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        gate[c*W +: W] = gold[c*W +: W];
        if ($urandom_range(0, 99) < 8) gate[c*W +: W] = gold[c*W +: W] ^ $urandom;
        valid[c] = ($urandom_range(0, 3) != 0);
      end
      tick();
    end
    clear = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
